// File: rtl/exec_mc_pkg.sv
// Shared types and helpers for the execute-stage multi-cycle hold slot.
package exec_mc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  function automatic int lat_sel(input logic div, input int mul_lat, input int div_lat);
    return div ? div_lat : mul_lat;
  endfunction

  // Counter holds LAT-1 at most; keep at least one bit so LAT=1 still builds.
  function automatic int cnt_width(input int mul_lat, input int div_lat);
    int m;
    m = (mul_lat > div_lat) ? mul_lat : div_lat;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/mc_lat_counter.sv
// Latency down-counter: clear beats load beats decrement; zero flags terminal count.
module mc_lat_counter #(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         Clr,
  input  logic         clear,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/exec_mc_stage.sv
// Execute-stage output register with a hold slot that parks mul/div payloads
// until the unit's latency has elapsed, then re-injects them with the result.
//
// state | meaning
// IDLE  | E register fed directly from decode; multi-cycle ops may start
// BUSY  | mul/div running, latency counter counting down, decode held off
// DONE  | result ready; parked payload + x_result written to E when not stalled
module exec_mc_stage
  import exec_mc_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 96,
  parameter int MUL_LAT   = 3,
  parameter int DIV_LAT   = 33
) (
  input  logic                 Clk,
  input  logic                 Clr,
  input  logic                 flush,
  input  logic                 dm_stall,
  input  logic                 d_valid,
  input  logic                 d_mc,
  input  logic                 d_div,
  input  logic [PAYLOAD_W-1:0] d_payload,
  input  logic [DATA_W-1:0]    d_data,
  output logic                 d_ready,
  output logic                 x_start,
  output logic                 x_cancel,
  input  logic [DATA_W-1:0]    x_result,
  output logic                 e_valid,
  output logic [PAYLOAD_W-1:0] e_payload,
  output logic [DATA_W-1:0]    e_data,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(MUL_LAT, DIV_LAT);

  mc_state_e            state;
  mc_state_e            state_nxt;
  logic                 accept;
  logic                 cnt_zero;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_load_val;
  logic [PAYLOAD_W-1:0] hold;

  assign accept       = d_valid & d_ready & ~flush;
  assign cnt_load_val = CNT_W'(lat_sel(d_div, MUL_LAT, DIV_LAT) - 1);

  mc_lat_counter #(
    .W (CNT_W)
  ) u_lat_cnt (
    .Clk      (Clk),
    .Clr      (Clr),
    .clear    (flush),
    .load     (x_start),
    .dec      ((state == BUSY) & ~cnt_zero),
    .load_val (cnt_load_val),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && d_mc) state_nxt = BUSY;
        BUSY:    if (cnt_zero) state_nxt = DONE;
        DONE:    if (!dm_stall) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Clr gating keeps handshakes quiet while the async reset is held.
  always_comb begin
    d_ready  = 1'b0;
    x_start  = 1'b0;
    x_cancel = 1'b0;
    busy     = 1'b0;
    d_ready  = ~Clr & (state == IDLE) & ~dm_stall;
    x_start  = accept & d_mc;
    x_cancel = ~Clr & flush & (state != IDLE);
    busy     = (state != IDLE);
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      hold      <= '0;
      e_valid   <= 1'b0;
      e_payload <= '0;
      e_data    <= '0;
    end else if (flush) begin
      e_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (d_mc) begin
              hold    <= d_payload;
              e_valid <= 1'b0;
            end else begin
              e_valid   <= 1'b1;
              e_payload <= d_payload;
              e_data    <= d_data;
            end
          end else if (!dm_stall) begin
            e_valid <= 1'b0;
          end
        end
        BUSY: begin
          if (!dm_stall) e_valid <= 1'b0;
        end
        DONE: begin
          if (!dm_stall) begin
            e_valid   <= 1'b1;
            e_payload <= hold;
            e_data    <= x_result;
          end
        end
        default: e_valid <= 1'b0;
      endcase
    end
  end

endmodule
